wb_arbiter_rr: RTL and testbench
================================

Name: wb_arbiter_rr

Overview:
- N-master to 1-slave Wishbone (classic, single-beat) arbiter with a round-robin grant.
- Lets a second bus master, e.g. a flash-to-SPRAM DMA or debug bridge, share the peripheral Wishbone bus (SPI, UART, RGB, USB xclk, EP buffer) with the CPU bridge.
- Sits between the masters and the existing address decoder.
- Registered grant; slave-side signals are muxed from the granted master.

Parameters:
- N, 2, number of masters (2..8).
- DW, 32, data width.
- AW, 16, address width.
- TO_W, 8, timeout counter width. Timeout fires after 2^TO_W-1 cycles without ack.

Ports:
- clk  in  1  bus clock.
- rst_n  in  1  asynchronous active-low reset.
- m_addr  in  N*AW  flattened master addresses; master i at [i*AW+:AW].
- m_wdata  in  N*DW  flattened master write data.
- m_wmsk  in  N*(DW/8)  flattened master byte masks.
- m_we  in  N  per-master write enable.
- m_cyc  in  N  per-master request.
- m_rdata  out  DW  read data, shared by all masters.
- m_ack  out  N  per-master ack.
- m_err  out  N  per-master timeout error pulse.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_wmsk  out  DW/8  slave byte mask.
- s_we  out  1  slave write enable.
- s_cyc  out  1  slave cycle.
- s_rdata  in  DW  slave read data.
- s_ack  in  1  slave ack.
- grant  out  N  one-hot current owner, for debug/status.

Behaviour:
- Reset values: state=IDLE, grant=0, last=N-1, m_ack=0, m_err=0, s_cyc=0, s_we=0, to_cnt=0.
- The s_addr/s_wdata/s_wmsk mux defaults to master 0 while idle.
- FSM states: IDLE, BUSY.
- IDLE, any m_cyc set:
  - Pick the first requesting index after last, searching (last+1) mod N upward with wrap.
  - Register a one-hot grant and go to BUSY.
  - Arbitration latency is 1 cycle: s_cyc rises the cycle after m_cyc.
- IDLE, no request: stay idle, grant=0.
- BUSY outputs:
  - s_cyc = m_cyc[g]; s_addr/s_wdata/s_wmsk/s_we come from master g (combinational mux).
  - m_ack[g] = s_ack & s_cyc; m_ack for other masters = 0.
  - m_rdata = s_rdata, unregistered.
- BUSY exit on ack (s_ack & s_cyc):
  - last <= g, grant <= 0, next state IDLE.
  - s_cyc is therefore low for at least 1 cycle between transactions, so slaves that ack on cyc do not double-ack.
- BUSY exit on abandon: if the granted master drops m_cyc before ack, go to IDLE and update last. No ack is issued.
- Simultaneous requests: strict round-robin. A master that just finished has lowest priority next.
  - With N=2 and both requesting continuously, grants alternate 0,1,0,1.
- A request arriving during BUSY waits. Requests are not latched; the master must hold m_cyc (standard WB).
- Async rst_n assertion mid-transaction: s_cyc and all acks drop immediately, the FSM returns to IDLE, and last resets to N-1.
  - First grant after reset therefore goes to master 0 if it is requesting.
- Out-of-range grant is impossible: grant is always one-hot or zero.
- The arbiter never modifies data width or byte masks.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN.
- Defined:
  - to_cnt (TO_W bits) clears on entering BUSY and increments every BUSY cycle without s_ack.
  - When to_cnt reaches 2^TO_W-1:
    - m_ack[g]=1 and m_err[g]=1 for one cycle, with m_rdata forced to all-ones.
    - s_cyc is dropped that same cycle and the FSM goes to IDLE with last <= g.
  - A real s_ack on the terminal-count cycle takes precedence: normal ack, no err.
- Undefined: no counter, m_err tied 0, and a hung slave holds the bus indefinitely.

Test Plan:
- Single master: N=2, master 0 reads addr 0x0010, slave acks 2 cycles after s_cyc with rdata 0xDEADBEEF.
  - s_cyc rises 1 cycle after m_cyc; m_ack[0] pulses once with m_rdata=0xDEADBEEF; m_ack[1]=0 throughout.
- Contention: both masters hold m_cyc from reset, slave acks on the first s_cyc cycle.
  - Grants go 0,1,0,1 with one idle cycle between each; s_cyc is never high for two consecutive transactions.
- Write routing: master 1 writes 0x12345678 with wmsk 0b0011 to 0x0200 while master 0 is idle.
  - s_we=1, s_addr=0x0200, s_wdata=0x12345678, s_wmsk=0b0011 while s_cyc=1.
- Abandon: master 0 drops m_cyc 1 cycle after grant with no ack, master 1 is requesting.
  - FSM goes IDLE, master 1 is granted next, and no m_ack[0] appears.
- Reset mid-cycle: assert rst_n=0 while BUSY with master 1 granted.
  - s_cyc=0 and grant=0 in the same cycle. After release with both requesting, master 0 is granted first.
- Timeout, with WB_ARBITER_TIMEOUT_EN and TO_W=4: slave never acks.
  - After 15 BUSY cycles, m_ack and m_err pulse together with m_rdata=0xFFFFFFFF, then the bus is released.

Source files
------------

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: N-master round-robin arbiter for a single-beat Wishbone classic bus.
// Define WB_ARBITER_TIMEOUT_EN to end a transaction with an error ack when the slave never answers.
module wb_arbiter_rr #(
  parameter int N    = 2,
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int TO_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N*AW-1:0]     m_addr,
  input  logic [N*DW-1:0]     m_wdata,
  input  logic [N*DW/8-1:0]   m_wmsk,
  input  logic [N-1:0]        m_we,
  input  logic [N-1:0]        m_cyc,
  output logic [DW-1:0]       m_rdata,
  output logic [N-1:0]        m_ack,
  output logic [N-1:0]        m_err,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_wdata,
  output logic [DW/8-1:0]     s_wmsk,
  output logic                s_we,
  output logic                s_cyc,
  input  logic [DW-1:0]       s_rdata,
  input  logic                s_ack,
  output logic [N-1:0]        grant
);
  localparam int LW = N > 1 ? $clog2(N) : 1;
  localparam int MW = DW / 8;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [LW-1:0] last_q, last_d, g, j;
  logic          busy, live, tc, done;
  always_comb begin
    g = '0;
    for (int i = 0; i < N; i++) if (grant_q[i]) g = LW'(i);
  end
  assign busy  = state_q == BUSY;
  assign live  = busy & m_cyc[g];
  assign done  = live & (s_ack | tc);
  assign grant = grant_q;
  // g is 0 while idle, so the slave-side mux rests on master 0
  assign s_addr  = m_addr[g*AW +: AW];
  assign s_wdata = m_wdata[g*DW +: DW];
  assign s_wmsk  = m_wmsk[g*MW +: MW];
  assign s_we    = busy & m_we[g];
  assign s_cyc   = live & ~tc;
  assign m_ack   = done ? N'(1) << g : '0;
  assign m_err   = tc ? N'(1) << g : '0;
  assign m_rdata = tc ? '1 : s_rdata;
`ifdef WB_ARBITER_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  assign tc       = live & ~s_ack & (&to_cnt_q);
  assign to_cnt_d = busy & ~s_ack ? to_cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
`else
  assign tc = 1'b0;
`endif
  // search starts just after the last owner, so it has lowest priority next
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    j       = '0;
    if (!busy) begin
      grant_d = '0;
      for (int i = N; i >= 1; i--) begin
        j = LW'((int'(last_q) + i) % N);
        if (m_cyc[j]) grant_d = N'(1) << j;
      end
      state_d = |m_cyc ? BUSY : IDLE;
    end else if (!live || done) begin
      state_d = IDLE;
      grant_d = '0;
      last_d  = g;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr: randomized masters and slave against a round-robin reference model with a scoreboard.
module tb_wb_arbiter_rr;
  localparam int N = 3, DW = 32, AW = 16, TO_W = 4, MW = DW / 8;
  localparam int TOMAX = (1 << TO_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N*MW-1:0] m_wmsk = '0;
  logic [N-1:0]    m_we = '0, m_cyc = '0;
  logic [DW-1:0]   s_rdata = '0;
  logic            s_ack = 1'b0;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ack, m_err, grant;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [MW-1:0]   s_wmsk;
  logic            s_we, s_cyc;

  wb_arbiter_rr #(.N(N), .DW(DW), .AW(AW), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmsk(m_wmsk),
    .m_we(m_we), .m_cyc(m_cyc), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmsk(s_wmsk), .s_we(s_we), .s_cyc(s_cyc),
    .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int req_pct[N];
  int hold_pct = 0, abandon_pct = 0, dly_min = 0, dly_max = 0;
  bit rd_fixed = 0;
  logic [N-1:0] acked = '0;
  int slv_cnt = 0, slv_dly = 0;
  logic [127:0] cq[$], aq[$];
  bit mbusy = 0;
  int mown = 0, mlast = N - 1, mcnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic new_req(input int i);
    m_cyc[i] = 1'b1;
    m_we[i] = 1'($urandom_range(1));
    m_addr[i*AW +: AW] = AW'($urandom);
    m_wdata[i*DW +: DW] = $urandom;
    m_wmsk[i*MW +: MW] = MW'($urandom);
  endtask

  // masters and slave: masters hold cyc until acked (or randomly abandon), slave acks after a random delay
  always @(negedge clk) acked = m_ack;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (m_cyc[i] && acked[i]) begin
        if ($urandom_range(99) < hold_pct) new_req(i);
        else m_cyc[i] = 1'b0;
      end else if (m_cyc[i]) begin
        if ($urandom_range(99) < abandon_pct) m_cyc[i] = 1'b0;
      end else if ($urandom_range(99) < req_pct[i]) new_req(i);
    end
    #1;
    if (s_cyc) begin
      s_ack = slv_cnt == slv_dly;
      s_rdata = rd_fixed ? 32'hDEADBEEF : $urandom;
      slv_cnt++;
    end else begin
      s_ack = 1'b0;
      slv_cnt = 0;
      slv_dly = $urandom_range(dly_max, dly_min);
    end
  end

  // reference model: bus owner chosen round-robin from the previous owner, one transaction at a time
  always @(negedge clk) begin
    logic [N-1:0] oh, eerr;
    logic [DW-1:0] erd;
    bit on, tcev;
    if (!rst_n) begin
      mbusy = 0;
      mlast = N - 1;
      cq.delete();
      aq.delete();
    end else if (mbusy) begin
      on = m_cyc[mown];
      tcev = 0;
`ifdef WB_ARBITER_TIMEOUT_EN
      tcev = on && !s_ack && mcnt == TOMAX;
`endif
      oh = '0;
      oh[mown] = 1'b1;
      eerr = tcev ? oh : '0;
      erd = tcev ? '1 : s_rdata;
      if (on && !tcev)
        cq.push_back(128'({oh, m_addr[mown*AW +: AW], m_wdata[mown*DW +: DW], m_wmsk[mown*MW +: MW], m_we[mown]}));
      if (on && (s_ack || tcev)) aq.push_back(128'({oh, eerr, erd}));
      mcnt++;
      if (!on || s_ack || tcev) begin
        mlast = mown;
        mbusy = 0;
      end
    end else if (|m_cyc) begin
      for (int k = 1; k <= N; k++)
        if (m_cyc[(mlast + k) % N]) begin
          mown = (mlast + k) % N;
          break;
        end
      mbusy = 1;
      mcnt = 0;
    end
  end

  // monitor: compare whenever the DUT drives a cycle or an ack
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (s_cyc) begin
        if (cq.size() == 0) chk("unexpected_cyc", 128'(s_cyc), 128'(0));
        else chk("cyc_route", 128'({grant, s_addr, s_wdata, s_wmsk, s_we}), cq.pop_front());
      end else if (cq.size() != 0) begin
        chk("missing_cyc", 128'(s_cyc), 128'(1));
        cq.delete();
      end
      if (m_ack != '0 || m_err != '0) begin
        if (aq.size() == 0) chk("unexpected_ack", 128'({m_ack, m_err}), 128'(0));
        else chk("ack_resp", 128'({m_ack, m_err, m_rdata}), aq.pop_front());
      end else if (aq.size() != 0) begin
        chk("missing_ack", 128'({m_ack, m_err, m_rdata}), aq.pop_front());
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < N; i++) req_pct[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_s_cyc", 128'(s_cyc), 128'(0));
    chk("rst_s_we", 128'(s_we), 128'(0));
    chk("rst_m_ack", 128'(m_ack), 128'(0));
    chk("rst_m_err", 128'(m_err), 128'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    // single master, fixed 2-cycle slave delay
    req_pct[0] = 100; dly_min = 2; dly_max = 2; rd_fixed = 1;
    repeat (30) @(posedge clk);
    // full contention, instant acks
    rd_fixed = 0; hold_pct = 100; dly_min = 0; dly_max = 0;
    for (int i = 0; i < N; i++) req_pct[i] = 100;
    repeat (40) @(posedge clk);
    // random mix with abandons
    hold_pct = 50; abandon_pct = 10; dly_max = 4;
    for (int i = 0; i < N; i++) req_pct[i] = 30;
    repeat (800) @(posedge clk);
    // reset while master 1 owns the bus
    abandon_pct = 0; hold_pct = 100; dly_min = 3; dly_max = 3;
    for (int i = 0; i < N; i++) req_pct[i] = 100;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(s_cyc && grant[1]) && k < 60);
    if (k >= 60) chk("wait_grant1", 128'(grant), 128'(2));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_s_cyc", 128'(s_cyc), 128'(0));
    chk("midrst_grant", 128'(grant), 128'(0));
    chk("midrst_m_ack", 128'(m_ack), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_grant", 128'(grant), 128'(1));
`ifdef WB_ARBITER_TIMEOUT_EN
    // slow slave straddling the terminal count
    hold_pct = 30; dly_min = 10; dly_max = 20;
    for (int i = 0; i < N; i++) req_pct[i] = 50;
    repeat (600) @(posedge clk);
`endif
    hold_pct = 0; dly_min = 0; dly_max = 2;
    for (int i = 0; i < N; i++) req_pct[i] = 0;
    repeat (40) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
